// File: rtl/mlp_neuron_acc.sv
// mlp_neuron_acc: accumulates NUM_INPUTS signed Q.20 products per neuron.
// It then adds a Q8.10 bias, rescales to Q8.10 with floor rounding,
// saturates, and presents the activation on a valid/ready port.
//
// Optional feature macro: MLP_NEURON_ACC_RELU_EN
//   defined   -> ReLU fused into the clamp (result range 0 .. 131071)
//   undefined -> symmetric signed saturation (-131072 .. 131071)
//
// Ports:
//   clk_i        rising-edge clock
//   reset_i      synchronous active-high reset
//   ce_i         clock enable; low holds all state and blocks handshakes
//   in_valid_i   in_data_i holds a product
//   in_ready_o   block can accept a product (ACC state only)
//   in_data_i    signed product, PROD_WIDTH bits
//   bias_i       signed Q8.10 bias, sampled in the FINAL state
//   out_valid_o  out_data_o holds a result
//   out_ready_i  downstream accepts the result
//   out_data_o   signed Q8.10 activation
//   busy_o       high outside ACC or while a neuron is partially accumulated
module mlp_neuron_acc #(
    parameter int unsigned PROD_WIDTH = 31,
    parameter int unsigned OUT_WIDTH  = 18,
    parameter int unsigned FRAC_BITS  = 10,
    parameter int unsigned ACC_WIDTH  = 40,
    parameter int unsigned NUM_INPUTS = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  ce_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [PROD_WIDTH-1:0] in_data_i,
    input  logic [OUT_WIDTH-1:0]  bias_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [OUT_WIDTH-1:0]  out_data_o,
    output logic                  busy_o
);

    // Count must be able to hold NUM_INPUTS after the last accept.
    localparam int unsigned CntWidth = $clog2(NUM_INPUTS + 1);

    localparam logic signed [ACC_WIDTH-1:0] MaxVal =
        {{(ACC_WIDTH - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
`ifndef MLP_NEURON_ACC_RELU_EN
    localparam logic signed [ACC_WIDTH-1:0] MinVal =
        {{(ACC_WIDTH - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};
`endif

    typedef enum logic [1:0] {StAcc, StFinal, StOut} state_e;

    state_e                        state_q, state_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [CntWidth-1:0]           count_q, count_d;
    logic                          out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0]          out_data_q, out_data_d;

    logic signed [ACC_WIDTH-1:0]   in_ext;
    logic signed [ACC_WIDTH-1:0]   bias_ext;
    logic signed [ACC_WIDTH-1:0]   sum;
    logic signed [ACC_WIDTH-1:0]   r;
    logic [OUT_WIDTH-1:0]          clamped;

    assign in_ext   = {{(ACC_WIDTH - PROD_WIDTH){in_data_i[PROD_WIDTH-1]}}, in_data_i};
    assign bias_ext = {{(ACC_WIDTH - OUT_WIDTH){bias_i[OUT_WIDTH-1]}}, bias_i};
    // Bias is aligned to the accumulator's Q.20 scale before the add.
    assign sum      = acc_q + (bias_ext <<< FRAC_BITS);
    // Arithmetic shift gives floor rounding toward minus infinity.
    assign r        = sum >>> FRAC_BITS;

    always_comb begin
        clamped = r[OUT_WIDTH-1:0];
`ifdef MLP_NEURON_ACC_RELU_EN
        if (r[ACC_WIDTH-1]) begin
            clamped = '0;
        end else if (r > MaxVal) begin
            clamped = MaxVal[OUT_WIDTH-1:0];
        end
`else
        if (r < MinVal) begin
            clamped = MinVal[OUT_WIDTH-1:0];
        end else if (r > MaxVal) begin
            clamped = MaxVal[OUT_WIDTH-1:0];
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (ce_i) begin
            unique case (state_q)
                StAcc: begin
                    if (in_valid_i) begin
                        acc_d   = acc_q + in_ext;
                        count_d = count_q + CntWidth'(1);
                        if (count_q == CntWidth'(NUM_INPUTS - 1)) begin
                            state_d = StFinal;
                        end
                    end
                end
                StFinal: begin
                    out_data_d  = clamped;
                    out_valid_d = 1'b1;
                    state_d     = StOut;
                end
                StOut: begin
                    if (out_ready_i) begin
                        out_valid_d = 1'b0;
                        acc_d       = '0;
                        count_d     = '0;
                        state_d     = StAcc;
                    end
                end
                default: state_d = StAcc;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StAcc;
            acc_q       <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready_o  = (state_q == StAcc);
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign busy_o      = (state_q != StAcc) || (count_q != '0);

endmodule

// File: tb/tb_mlp_neuron_acc.sv
// Testbench for mlp_neuron_acc with NUM_INPUTS = 4 and default widths.
module tb_mlp_neuron_acc;

    localparam int NI = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        in_valid;
    logic        in_ready;
    logic [30:0] in_data;
    logic [17:0] bias;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_data;
    logic        busy;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mlp_neuron_acc #(
        .PROD_WIDTH(31),
        .OUT_WIDTH (18),
        .FRAC_BITS (10),
        .ACC_WIDTH (40),
        .NUM_INPUTS(NI)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .ce_i       (ce),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .bias_i     (bias),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .busy_o     (busy)
    );

    // Reference: exact integer sum, floor division by 2^10, then clamp.
    function automatic logic [17:0] model(input int p[NI], input int b);
        longint s = 0;
        longint r;
        for (int i = 0; i < NI; i++) s += longint'(p[i]);
        s += longint'(b) * 1024;
        r = s / 1024;
        if (s < 0 && (s % 1024) != 0) r -= 1;
`ifdef MLP_NEURON_ACC_RELU_EN
        if (r < 0) r = 0;
`else
        if (r < -131072) r = -131072;
`endif
        if (r > 131071) r = 131071;
        return 18'(r);
    endfunction

    // Feeds one neuron's products and waits for out_valid without accepting it.
    // lat = 1 + enabled edges after the last accepting edge until out_valid is seen.
    task automatic run_neuron(input int p[NI], input int b, input bit toggle,
                              output logic [17:0] res, output int lat, output bit ok);
        int idx = 0;
        int en_after = 0;
        int cyc = 0;
        bit acc;
        ok = 1'b0;
        res = '0;
        lat = 0;
        out_ready = 1'b0;
        bias = 18'(b);
        while (cyc < 200) begin
            @(negedge clk);
            if (idx == NI && out_valid) begin
                ok = 1'b1;
                res = out_data;
                lat = 1 + en_after;
                break;
            end
            ce = toggle ? (cyc % 2 == 0) : 1'b1;
            in_valid = (idx < NI);
            if (idx < NI) in_data = 31'(p[idx]);
            else in_data = '0;
            acc = in_valid && in_ready && ce;
            @(posedge clk);
            if (idx == NI && ce) en_after++;
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        ce = 1'b1;
        if (!ok) begin
            nvec++;
            nerr++;
            $display("FAIL run_neuron_timeout: out_valid not seen, accepted %0d of %0d", idx, NI);
        end
    endtask

    task automatic accept_output();
        @(negedge clk);
        ce = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ce = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        bias = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        nvec++;
        if (out_valid !== 1'b0 || out_data !== 18'd0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            nerr++;
            $display("FAIL reset_state: got v=%b d=%h rdy=%b busy=%b, want v=0 d=0 rdy=1 busy=0",
                     out_valid, out_data, in_ready, busy);
        end
    endtask

    task automatic test_basic();
        int p[NI] = '{1024, 1024, 1024, 1024};
        logic [17:0] res;
        int lat;
        bit ok;
        run_neuron(p, 0, 1'b0, res, lat, ok);
        if (ok) begin
            nvec++;
            if (res !== 18'd4) begin
                nerr++;
                $display("FAIL basic_sum: got %h want %h", res, 18'd4);
            end
            nvec++;
            if (lat !== 2) begin
                nerr++;
                $display("FAIL basic_latency: got %0d want 2", lat);
            end
        end
        accept_output();
        @(negedge clk);
        nvec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL basic_after_accept: got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed(input string name, input int p[NI], input int b,
                                 input logic [17:0] want);
        logic [17:0] res;
        int lat;
        bit ok;
        run_neuron(p, b, 1'b0, res, lat, ok);
        if (ok) begin
            nvec++;
            if (res !== want) begin
                nerr++;
                $display("FAIL %s: got %h want %h", name, res, want);
            end
        end
        accept_output();
    endtask

    task automatic test_values();
        int pn[NI] = '{-2048, -2048, -2048, -2048};
        int pm[NI] = '{-1, 0, 0, 0};
        int ps[NI] = '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h3FFFFFFF, 32'h3FFFFFFF};
        int pz[NI] = '{0, 0, 0, 0};
`ifdef MLP_NEURON_ACC_RELU_EN
        test_directed("negative_sum", pn, 0, 18'h00000);
        test_directed("floor_minus_one", pm, 0, 18'h00000);
        test_directed("bias_only", pz, -512, 18'h00000);
`else
        test_directed("negative_sum", pn, 0, 18'h3FFF8);
        test_directed("floor_minus_one", pm, 0, 18'h3FFFF);
        test_directed("bias_only", pz, -512, 18'h3FE00);
`endif
        test_directed("saturate_high", ps, 0, 18'h1FFFF);
    endtask

    task automatic test_backpressure();
        int p[NI] = '{1024, 1024, 1024, 1024};
        logic [17:0] res;
        int lat;
        bit ok;
        run_neuron(p, 0, 1'b0, res, lat, ok);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data = 31'h00FACE00;
            out_ready = 1'b0;
            nvec++;
            if (out_valid !== 1'b1 || out_data !== 18'd4 || in_ready !== 1'b0) begin
                nerr++;
                $display("FAIL backpressure_hold: cyc %0d got v=%b d=%h rdy=%b want v=1 d=4 rdy=0",
                         i, out_valid, out_data, in_ready);
            end
        end
        in_valid = 1'b0;
        accept_output();
        run_neuron(p, 0, 1'b0, res, lat, ok);
        if (ok) begin
            nvec++;
            if (res !== 18'd4) begin
                nerr++;
                $display("FAIL backpressure_next: got %h want %h", res, 18'd4);
            end
        end
        accept_output();
    endtask

    task automatic test_reset_mid();
        int p[NI] = '{1024, 1024, 1024, 1024};
        logic [17:0] res;
        int lat;
        bit ok;
        @(negedge clk);
        ce = 1'b1;
        in_valid = 1'b1;
        in_data = 31'd1024;
        repeat (2) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        nvec++;
        if (busy !== 1'b0) begin
            nerr++;
            $display("FAIL reset_mid_busy: got %b want 0", busy);
        end
        run_neuron(p, 0, 1'b0, res, lat, ok);
        if (ok) begin
            nvec++;
            if (res !== 18'd4) begin
                nerr++;
                $display("FAIL reset_mid_sum: got %h want %h", res, 18'd4);
            end
        end
        // Result is held; reset must drop it.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        nvec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL reset_in_out: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_ce_gating();
        int p[NI] = '{1024, 1024, 1024, 1024};
        logic [17:0] res;
        int lat;
        bit ok;
        run_neuron(p, 0, 1'b1, res, lat, ok);
        if (ok) begin
            nvec++;
            if (res !== 18'd4) begin
                nerr++;
                $display("FAIL ce_sum: got %h want %h", res, 18'd4);
            end
            nvec++;
            if (lat !== 2) begin
                nerr++;
                $display("FAIL ce_latency: got %0d want 2", lat);
            end
        end
        // With ce low, out_ready must not complete the handshake.
        @(negedge clk);
        ce = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nvec++;
        if (out_valid !== 1'b1 || out_data !== 18'd4) begin
            nerr++;
            $display("FAIL ce_hold_output: got v=%b d=%h want v=1 d=4", out_valid, out_data);
        end
        out_ready = 1'b0;
        ce = 1'b1;
        accept_output();
    endtask

    task automatic test_random();
        int p[NI];
        int b;
        logic [17:0] res;
        logic [17:0] want;
        int lat;
        bit ok;
        bit tog;
        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < NI; i++) begin
                if ($urandom_range(0, 1) == 0) p[i] = int'($signed(31'($urandom)));
                else p[i] = int'($urandom_range(0, 32'h07FFFFFF)) - 32'sh04000000;
            end
            b = int'($signed(18'($urandom)));
            tog = 1'($urandom_range(0, 1));
            want = model(p, b);
            run_neuron(p, b, tog, res, lat, ok);
            if (ok) begin
                nvec++;
                if (res !== want) begin
                    nerr++;
                    $display("FAIL random_data[%0d]: got %h want %h", n, res, want);
                end
                nvec++;
                if (lat !== 2) begin
                    nerr++;
                    $display("FAIL random_latency[%0d]: got %0d want 2", n, lat);
                end
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            accept_output();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_values();
        test_backpressure();
        test_reset_mid();
        test_ce_gating();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mlp_neuron_acc.md
Name: mlp_neuron_acc

Overview:
- Downstream consumer of the pipelined 18x18 signed neuron multiplier; receives its 31-bit products one per accepted beat.
- Accumulates NUM_INPUTS products into one wide sum, adds an aligned bias, and rescales the result to the 18-bit Q8.10 activation format.
- Saturates the result and presents one activation per neuron on a valid/ready output port for the next layer's input buffer.

Parameters:
- PROD_WIDTH, 31, product width; signed, Q.20 fixed point.
- OUT_WIDTH, 18, activation and bias width; signed, Q8.10.
- FRAC_BITS, 10, fraction bits of OUT_WIDTH format; also the rescale shift amount.
- ACC_WIDTH, 40, accumulator width; must be >= PROD_WIDTH + clog2(NUM_INPUTS) + 1. No overflow check; the accumulator wraps if this is violated.
- NUM_INPUTS, 16, products per neuron; must be >= 1.

Ports:
- clk, input, 1: clock; all registers update on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- ce, input, 1: clock enable; when low, all registers hold and no handshake completes.
- in_valid, input, 1: in_data holds a product; upstream aligns it to the multiplier latency.
- in_ready, output, 1: block can accept a product.
- in_data, input, PROD_WIDTH: signed product.
- bias, input, OUT_WIDTH: signed Q8.10 neuron bias; sampled in the FINAL state.
- out_valid, output, 1: out_data holds a result.
- out_ready, input, 1: downstream accepts the result.
- out_data, output, OUT_WIDTH: signed Q8.10 activation.
- busy, output, 1: high in any state other than ACC, or when count != 0.

Behaviour:
- Reset values:
  - state = ACC
  - acc = 0
  - count = 0
  - out_valid = 0
  - out_data = 0
  - in_ready = 1
- A reset in any state, including mid-accumulation or while a result is held, discards all partial state.
- A register update or handshake takes effect only when ce = 1.
- Input accept: in_valid & in_ready & ce.
- Output accept: out_valid & out_ready & ce.
- State ACC:
  - in_ready = 1.
  - On accept: acc <= acc + sign_extend(in_data); count <= count + 1.
  - On the accept with count == NUM_INPUTS-1: go to FINAL.
- State FINAL (one cycle):
  - in_ready = 0.
  - sum = acc + (sign_extend(bias) << FRAC_BITS).
  - r = sum >>> FRAC_BITS (arithmetic shift, floor rounding; -1 >>> 10 = -1).
  - out_data <= clamp(r).
  - out_valid <= 1; go to OUT.
- State OUT:
  - in_ready = 0; out_data is stable while out_valid = 1.
  - On output accept: out_valid <= 0; acc <= 0; count <= 0; go to ACC.
  - The next product can be accepted one cycle after the output accept.
- Latency: out_valid rises 2 enabled cycles after the cycle that accepts the last product.
- Back-to-back neuron throughput: NUM_INPUTS + 2 cycles.
- If ce drops during FINAL, FINAL is extended; bias must remain stable until the FINAL cycle has completed with ce = 1.
- Products arriving while in_ready = 0 are not consumed; upstream holds them.
- clamp: the upper bound is always 2^(OUT_WIDTH-1)-1 = 131071. The lower bound is set by the optional feature below.

Optional Feature:
- Macro: MLP_NEURON_ACC_RELU_EN.
- Defined: ReLU is fused into the clamp. r < 0 gives 0; r > 131071 gives 131071.
- Undefined: symmetric signed saturation. r < -131072 gives -131072; r > 131071 gives 131071.

Test Plan:
- Basic sum: NUM_INPUTS=4, bias=0, products 1024,1024,1024,1024 with in_valid held high -> out_valid rises 2 cycles after the 4th accept; out_data=4.
- Negative result: products -2048 x4, bias=0 -> out_data=0 with RELU_EN defined; out_data=-8 (0x3FFF8) with it undefined. Products -1 x1, others 0 -> -1 (floor), or 0 under ReLU.
- Saturation and bias: products 0x3FFFFFFF x4 -> out_data=131071. Products 0 x4 with bias=-512 -> -512 without ReLU, 0 with ReLU.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises -> out_valid=1, out_data constant, in_ready=0 throughout. Offered products are not consumed. On out_ready=1, the next vector (1024 x4) gives 4.
- Reset mid-operation: pulse reset after 2 accepted products of 1024, then feed 4 x 1024 -> out_data=4, not 6. Reset asserted during OUT -> out_valid=0 on the next cycle.
- ce gating: toggle ce low every other cycle during accumulation and in FINAL -> same result as ce=1, with latency measured in enabled cycles. No count change while ce=0.
